// File: rtl/rgb_pwm_fader.sv
// Multi-channel PWM LED driver: shared prescaled period counter, per-channel polarity,
// boundary-synchronous duty loads. Define RGB_PWM_FADE_EN to build the per-period fade engine.
module rgb_pwm_fader #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic                         pwm_clk,
  input  logic                         reset_n,
  input  logic [CHANNELS*WIDTH-1:0]    duty_in,
  input  logic [CHANNELS-1:0]          invert_in,
  input  logic [WIDTH-1:0]             fade_step,
  input  logic                         load_valid,
  output logic                         load_ready,
  output logic [CHANNELS-1:0]          pwm_out,
  output logic                         period_start,
  output logic                         busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]       presc;
  logic                tick;
  logic                boundary;
  logic                accept;
  logic                pending;
  logic [WIDTH-1:0]    count;
  logic [WIDTH-1:0]    count_nxt;
  logic [WIDTH-1:0]    active     [CHANNELS];
  logic [WIDTH-1:0]    active_nxt [CHANNELS];
  logic [WIDTH-1:0]    target     [CHANNELS];
  logic [CHANNELS-1:0] inv_act;
  logic [CHANNELS-1:0] inv_act_nxt;
  logic [CHANNELS-1:0] inv_pend;

`ifdef RGB_PWM_FADE_EN
  // Step toward tgt, landing exactly on it instead of overshooting; zero step jumps.
  function automatic logic [WIDTH-1:0] fade_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt,
                                                   input logic [WIDTH-1:0] step);
    if (step == '0 || cur == tgt) return tgt;
    if (cur < tgt) return ((tgt - cur) <= step) ? tgt : cur + step;
    return ((cur - tgt) <= step) ? tgt : cur - step;
  endfunction
`else
  logic unused_fade_step;
  assign unused_fade_step = ^fade_step;
`endif

  assign tick       = (presc == PW'(PRESCALE - 1));
  assign boundary   = tick && (count == '1);
  assign accept     = load_valid && !pending;
  assign load_ready = !pending;
  assign count_nxt  = tick ? count + 1'b1 : count;

  // Next-period state is computed ahead so the pin register sees the new duty and
  // polarity in the same cycle that period_start is raised.
  always_comb begin
    inv_act_nxt = (boundary && pending) ? inv_pend : inv_act;
    for (int k = 0; k < CHANNELS; k++) begin
      active_nxt[k] = active[k];
`ifdef RGB_PWM_FADE_EN
      if (boundary) active_nxt[k] = fade_toward(active[k], target[k], fade_step);
`else
      if (boundary && pending) active_nxt[k] = target[k];
`endif
    end
  end

  always_comb begin
    busy = pending;
`ifdef RGB_PWM_FADE_EN
    for (int k = 0; k < CHANNELS; k++) begin
      if (active[k] != target[k]) busy = 1'b1;
    end
`endif
  end

  always_ff @(posedge pwm_clk or negedge reset_n) begin
    if (!reset_n) begin
      presc        <= '0;
      count        <= '0;
      inv_act      <= '0;
      inv_pend     <= '0;
      pending      <= 1'b0;
      pwm_out      <= '0;
      period_start <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        active[k] <= '0;
        target[k] <= '0;
      end
    end else begin
      presc        <= tick ? '0 : presc + 1'b1;
      count        <= count_nxt;
      inv_act      <= inv_act_nxt;
      period_start <= boundary;
      for (int k = 0; k < CHANNELS; k++) begin
        active[k]  <= active_nxt[k];
        pwm_out[k] <= (count_nxt < active_nxt[k]) ^ inv_act_nxt[k];
      end
      // A load landing on a boundary edge sees pending=0 here, so it waits a full period.
      if (boundary && pending) pending <= 1'b0;
      if (accept) begin
        pending  <= 1'b1;
        inv_pend <= invert_in;
        for (int k = 0; k < CHANNELS; k++) target[k] <= duty_in[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader: two instances (PRESCALE 1 and 4) against a period-arithmetic model.
module tb_rgb_pwm_fader;
  localparam int CH = 3;
  localparam int W  = 8;
  localparam int M  = 256;
`ifdef RGB_PWM_FADE_EN
  localparam bit FADE = 1'b1;
`else
  localparam bit FADE = 1'b0;
`endif

  logic                 pwm_clk = 1'b0;
  logic                 reset_n = 1'b1;
  logic [CH*W-1:0]      duty_in = '0;
  logic [CH-1:0]        invert_in = '0;
  logic [W-1:0]         fade_step = '0;
  logic                 load_valid = 1'b0;
  logic [1:0]           load_ready;
  logic [1:0]           period_start;
  logic [1:0]           busy;
  logic [1:0][CH-1:0]   pwm;

  int errors = 0;
  int checks = 0;

  always #5 pwm_clk = ~pwm_clk;

  rgb_pwm_fader #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(1)) u_p1 (
    .pwm_clk(pwm_clk), .reset_n(reset_n), .duty_in(duty_in), .invert_in(invert_in),
    .fade_step(fade_step), .load_valid(load_valid), .load_ready(load_ready[0]),
    .pwm_out(pwm[0]), .period_start(period_start[0]), .busy(busy[0]));

  rgb_pwm_fader #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(4)) u_p4 (
    .pwm_clk(pwm_clk), .reset_n(reset_n), .duty_in(duty_in), .invert_in(invert_in),
    .fade_step(fade_step), .load_valid(load_valid), .load_ready(load_ready[1]),
    .pwm_out(pwm[1]), .period_start(period_start[1]), .busy(busy[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int n      [2];
  bit pend   [2];
  int tgt    [2][CH];
  int act    [2][CH];
  bit inv_p  [2][CH];
  bit inv_a  [2][CH];

  function automatic int pre_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int fade_model(input int cur, input int goal, input int step);
    int d;
    d = goal - cur;
    if (step == 0 || (d <= step && d >= -step)) return goal;
    return (d > 0) ? cur + step : cur - step;
  endfunction

  function automatic void model_step(input int i);
    bit bnd;
    bit was_p;
    bnd   = ((n[i] + 1) % (pre_of(i) * M)) == 0;
    was_p = pend[i];
    if (bnd) begin
      for (int k = 0; k < CH; k++) begin
        if (FADE) act[i][k] = fade_model(act[i][k], tgt[i][k], int'(fade_step));
        if (was_p) begin
          inv_a[i][k] = inv_p[i][k];
          if (!FADE) act[i][k] = tgt[i][k];
        end
      end
      if (was_p) pend[i] = 1'b0;
    end
    if (load_valid && !was_p) begin
      for (int k = 0; k < CH; k++) begin
        tgt[i][k]   = int'(duty_in[k*W +: W]);
        inv_p[i][k] = invert_in[k];
      end
      pend[i] = 1'b1;
    end
    n[i] = n[i] + 1;
  endfunction

  always @(posedge pwm_clk or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        n[i] = 0;
        pend[i] = 1'b0;
        for (int k = 0; k < CH; k++) begin
          tgt[i][k] = 0; act[i][k] = 0; inv_p[i][k] = 1'b0; inv_a[i][k] = 1'b0;
        end
      end else begin
        model_step(i);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge pwm_clk) begin
    for (int i = 0; i < 2; i++) begin
      int cnt;
      logic [CH-1:0] ep;
      logic eb;
      cnt = (n[i] / pre_of(i)) % M;
      eb  = pend[i];
      for (int k = 0; k < CH; k++) begin
        ep[k] = (cnt < act[i][k]) ^ inv_a[i][k];
        if (act[i][k] != tgt[i][k]) eb = 1'b1;
      end
      check($sformatf("pwm_out[%0d]", i), 32'(pwm[i]), 32'(ep));
      check($sformatf("period_start[%0d]", i), 32'(period_start[i]),
            32'(n[i] > 0 && (n[i] % (pre_of(i) * M)) == 0));
      check($sformatf("load_ready[%0d]", i), 32'(load_ready[i]), 32'(!pend[i]));
      check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(eb));
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_load(input logic [CH*W-1:0] d, input logic [CH-1:0] inv);
    int t;
    t = 0;
    while (load_ready != 2'b11 && t < 3000) begin
      @(negedge pwm_clk);
      t++;
    end
    check("ready_wait", 32'(t < 3000), 32'd1);
    #1;
    duty_in    = d;
    invert_in  = inv;
    load_valid = 1'b1;
    @(negedge pwm_clk);
    #1;
    load_valid = 1'b0;
    check("ready_low_after_load", 32'(load_ready), 32'd0);
  endtask

  task automatic wait_ps(input int i, output int t);
    t = 0;
    while (!period_start[i] && t < 3000) begin
      @(negedge pwm_clk);
      t++;
    end
    check("ps_wait", 32'(t < 3000), 32'd1);
  endtask

  task automatic measure(input int i, output int hi [CH], output logic b0);
    int t;
    wait_ps(i, t);
    b0 = busy[i];
    for (int k = 0; k < CH; k++) hi[k] = 0;
    repeat (pre_of(i) * M) begin
      for (int k = 0; k < CH; k++) if (pwm[i][k]) hi[k]++;
      @(negedge pwm_clk);
    end
  endtask

  initial begin
    int hi [CH];
    logic b;
    int t;
    int exp_fade [4];
    logic exp_busy [4];

    #1 reset_n = 1'b0;
    repeat (3) @(negedge pwm_clk);
    #3 reset_n = 1'b1;
    @(negedge pwm_clk);
    check("idle_ready", 32'(load_ready), 32'd3);
    check("idle_pwm", 32'(pwm), 32'd0);

    measure(0, hi, b);
    for (int k = 0; k < CH; k++) check($sformatf("idle_hi[%0d]", k), 32'(hi[k]), 32'd0);

    // duties 00/80/FF, no inversion
    do_load({8'hFF, 8'h80, 8'h00}, 3'b000);
    measure(0, hi, b);
    check("basic_ch0", 32'(hi[0]), 32'd0);
    check("basic_ch1", 32'(hi[1]), 32'd128);
    check("basic_ch2", 32'(hi[2]), 32'd255);

    // inverted ch1 at 0x40, loaded mid-period
    repeat (100) @(negedge pwm_clk);
    do_load({8'hFF, 8'h40, 8'h00}, 3'b010);
    measure(0, hi, b);
    check("inv_ch1_high", 32'(hi[1]), 32'd192);
    check("inv_ch2_high", 32'(hi[2]), 32'd255);
    check("ready_after_apply", 32'(load_ready[0]), 32'd1);

    // PRESCALE=4 instance
    do_load({8'hFF, 8'h40, 8'h10}, 3'b010);
    measure(1, hi, b);
    check("p4_ch0", 32'(hi[0]), 32'd64);
    check("p4_ch1", 32'(hi[1]), 32'd768);
    check("p4_ch2", 32'(hi[2]), 32'd1020);

    // fade 0 -> 0xA0 with step 0x30 (whole jump without the fade engine)
    do_load({8'hFF, 8'h40, 8'h00}, 3'b010);
    fade_step = 8'h30;
    do_load({8'hFF, 8'h40, 8'hA0}, 3'b010);
    exp_fade = FADE ? '{48, 96, 144, 160} : '{160, 160, 160, 160};
    exp_busy = FADE ? '{1'b1, 1'b1, 1'b1, 1'b0} : '{1'b0, 1'b0, 1'b0, 1'b0};
    for (int s = 0; s < 4; s++) begin
      measure(0, hi, b);
      check($sformatf("fade_hi[%0d]", s), 32'(hi[0]), 32'(exp_fade[s]));
      check($sformatf("fade_busy[%0d]", s), 32'(b), 32'(exp_busy[s]));
    end

    // asynchronous reset mid-pulse / mid-fade
    do_load({8'hFF, 8'h40, 8'h10}, 3'b010);
    wait_ps(0, t);
    repeat (20) @(negedge pwm_clk);
    check("pre_reset_ch2_high", 32'(pwm[0][2]), 32'd1);
    check("pre_reset_busy", 32'(busy[0]), 32'(FADE));
    #3 reset_n = 1'b0;
    #1;
    check("async_pwm", 32'(pwm), 32'd0);
    check("async_ps", 32'(period_start), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_ready", 32'(load_ready), 32'd3);
    repeat (2) @(negedge pwm_clk);
    #3 reset_n = 1'b1;
    t = 0;
    while (!period_start[0] && t < 3000) begin
      @(negedge pwm_clk);
      t++;
    end
    check("post_reset_first_ps", 32'(t), 32'd256);
    measure(0, hi, b);
    for (int k = 0; k < CH; k++) check($sformatf("post_reset_hi[%0d]", k), 32'(hi[k]), 32'd0);
    check("post_reset_ready", 32'(load_ready), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
